// File: rtl/exe_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states and the per-op latency helper.
package exe_pkg;

    localparam logic [2:0] OP_MUL   = 3'd0;
    localparam logic [2:0] OP_MULH  = 3'd1;
    localparam logic [2:0] OP_MULHU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_REM   = 3'd5;
    localparam logic [2:0] OP_REMU  = 3'd6;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    function automatic logic op_is_div(input logic [2:0] op);
        return (op >= OP_DIV) && (op <= OP_REMU);
    endfunction

    // Cycles from accept edge to out_valid; the final cycle is the sign fix-up.
    function automatic int unsigned op_lat(input logic [2:0] op,
                                           input int unsigned xlen,
                                           input int unsigned unroll);
        return op_is_div(op) ? xlen + 1 : xlen / unroll + 1;
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Shift-add multiplier (UNROLL bits/step) and restoring divider (1 bit/step).
// MULDIV_SIGNED_EN selects two's-complement handling of MULH/DIV/REM.
module muldiv_datapath
    import exe_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            step_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] res_o
);

`ifdef MULDIV_SIGNED_EN
    localparam logic SIGNED_EN = 1'b1;
`else
    localparam logic SIGNED_EN = 1'b0;
`endif

    // acc_q: product high half / partial remainder; lo_q: multiplier / quotient.
    logic [XLEN-1:0] acc_q, lo_q, opnd_q;
    logic            div_q, sel_q, negq_q, negr_q, bzero_q;

    logic            sgn, neg_a, neg_b;
    logic [XLEN-1:0] abs_a, abs_b;

    always_comb begin
        sgn   = SIGNED_EN && (op_i == OP_MULH || op_i == OP_DIV || op_i == OP_REM);
        neg_a = sgn & a_i[XLEN-1];
        neg_b = sgn & b_i[XLEN-1];
        abs_a = neg_a ? -a_i : a_i;
        abs_b = neg_b ? -b_i : b_i;
    end

    logic [XLEN+UNROLL-1:0] partial, sum;
    logic [XLEN:0]          shifted, trial;

    always_comb begin
        partial = '0;
        for (int unsigned i = 0; i < UNROLL; i++) begin
            if (lo_q[i]) partial = partial + ({{UNROLL{1'b0}}, opnd_q} << i);
        end
        sum     = {{UNROLL{1'b0}}, acc_q} + partial;
        shifted = {acc_q, lo_q[XLEN-1]};
        trial   = shifted - {1'b0, opnd_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= '0;
            lo_q    <= '0;
            opnd_q  <= '0;
            div_q   <= 1'b0;
            sel_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            bzero_q <= 1'b0;
        end else if (load_i) begin
            acc_q   <= '0;
            lo_q    <= abs_a;
            opnd_q  <= abs_b;
            div_q   <= op_is_div(op_i);
            sel_q   <= (op_i == OP_MULH) || (op_i == OP_MULHU) ||
                       (op_i == OP_REM)  || (op_i == OP_REMU);
            negq_q  <= neg_a ^ neg_b;
            negr_q  <= neg_a;
            bzero_q <= (b_i == '0);
        end else if (step_i) begin
            if (div_q) begin
                if (!trial[XLEN]) begin
                    acc_q <= trial[XLEN-1:0];
                    lo_q  <= {lo_q[XLEN-2:0], 1'b1};
                end else begin
                    acc_q <= shifted[XLEN-1:0];
                    lo_q  <= {lo_q[XLEN-2:0], 1'b0};
                end
            end else begin
                acc_q <= sum[XLEN+UNROLL-1:UNROLL];
                lo_q  <= {sum[UNROLL-1:0], lo_q[XLEN-1:UNROLL]};
            end
        end
    end

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot, rem;

    // Divide-by-zero keeps an all-ones quotient regardless of dividend sign.
    always_comb begin
        prod = {acc_q, lo_q};
        if (negq_q) prod = -prod;
        quot = bzero_q ? '1 : (negq_q ? -lo_q : lo_q);
        rem  = negr_q ? -acc_q : acc_q;
        if (div_q) res_o = sel_q ? rem : quot;
        else       res_o = sel_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    end

endmodule

// File: rtl/exe_muldiv_iter.sv
// Iterative mul/div unit for EXE: handshake FSM, latency counter, tag/result regs.
// MULDIV_SIGNED_EN enables signed MULH/DIV/REM in the datapath.
module exe_muldiv_iter
    import exe_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned UNROLL = 1,
    parameter int unsigned TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] tag_out
);

    localparam int unsigned CNT_W = $clog2(XLEN + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TAG_W-1:0]   tag_pend_q, tag_q;
    logic [XLEN-1:0]    result_q, dp_res;
    logic               load, step, fix;

    muldiv_datapath #(
        .XLEN   (XLEN),
        .UNROLL (UNROLL)
    ) u_dp (
        .clk    (clk),
        .rst    (rst),
        .load_i (load),
        .step_i (step),
        .op_i   (op),
        .a_i    (a),
        .b_i    (b),
        .res_o  (dp_res)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step    = 1'b0;
        fix     = 1'b0;
        case (state_q)
            IDLE: if (in_valid) begin
                load    = 1'b1;
                state_d = BUSY;
                cnt_d   = CNT_W'(op_lat(op, XLEN, UNROLL) - 1);
            end
            BUSY: if (cnt_q == '0) begin
                fix     = 1'b1;
                state_d = DONE;
            end else begin
                step    = 1'b1;
                cnt_d   = cnt_q - CNT_W'(1);
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Flush overrides accept, completion and drain alike.
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            load    = 1'b0;
            step    = 1'b0;
            fix     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            tag_pend_q <= '0;
            tag_q      <= '0;
            result_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load) tag_pend_q <= tag_in;
            if (fix) begin
                result_q <= dp_res;
                tag_q    <= tag_pend_q;
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign tag_out   = tag_q;

endmodule
